// File: rtl/fpu_pkg.sv
// Shared FP datapath definitions: rounding-mode encodings and the
// norm/round sequencer state encoding.
package fpu_pkg;

   localparam logic [1:0] RM_RNE  = 2'b00;
   localparam logic [1:0] RM_RTZ  = 2'b01;
   localparam logic [1:0] RM_PINF = 2'b10;
   localparam logic [1:0] RM_NINF = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      NORM   = 3'd1,
      ROUND  = 3'd2,
      RENORM = 3'd3,
      DONE   = 3'd4
   } nr_state_t;

endpackage

// File: rtl/lden_reg.sv
// W-bit load-enable register with synchronous active-high clear.
module lden_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)     q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/round_incr.sv
// Round-up decision bit from guard, sticky, lsb and sign for the four
// IEEE rounding modes; shared with the adder path.
module round_incr
   import fpu_pkg::*;
(
   input  logic       g,
   input  logic       s,
   input  logic       lsb,
   input  logic       sign,
   input  logic [1:0] rmode,
   output logic       r
);

   always_comb begin
      r = 1'b0;
      case (rmode)
         RM_RNE:  r = g & (s | lsb);
         RM_RTZ:  r = 1'b0;
         RM_PINF: r = (g | s) & ~sign;
         default: r = (g | s) & sign;
      endcase
   end

endmodule

// File: rtl/sgf_norm_round.sv
// Post-multiply normalise/round stage: 2*SW-bit significand product in,
// SW-1 rounded fraction bits plus exponent increment out.
module sgf_norm_round
   import fpu_pkg::*;
#(
   parameter int SW = 24
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2*SW-1:0] sgf_prod_i,
   input  logic            sign_i,
   input  logic [1:0]      rmode_i,
   output logic            ready_o,
   output logic            valid_o,
   output logic [SW-2:0]   sgf_frac_o,
   output logic [1:0]      exp_inc_o,
   output logic            inexact_o,
   output logic            zero_o
);

   nr_state_t state;

   logic            ld_op;
   logic [2*SW-1:0] prod_q;
   logic            sign_q;
   logic [1:0]      rmode_q;

   assign ld_op = (state == IDLE) && start_i;

   lden_reg #(.W(2*SW+3)) u_op_reg (
      .clk (clk), .rst (rst), .en (ld_op),
      .d   ({sgf_prod_i, sign_i, rmode_i}),
      .q   ({prod_q, sign_q, rmode_q})
   );

   // Only the fraction below the hidden bit is kept: with a hidden 1, the
   // significand overflows on round-up exactly when the fraction does.
   logic [SW-2:0] frac_d, frac_q;
   logic          g_d, s_d, inc_d, zero_d;
   logic          g_q, s_q, inc_q, zero_q;

   always_comb begin
      zero_d = (prod_q[2*SW-1:2*SW-2] == 2'b00);
      if (prod_q[2*SW-1]) begin
         frac_d = prod_q[2*SW-2:SW];
         g_d    = prod_q[SW-1];
         s_d    = |prod_q[SW-2:0];
         inc_d  = 1'b1;
      end else begin
         frac_d = prod_q[2*SW-3:SW-1];
         g_d    = prod_q[SW-2];
         s_d    = |prod_q[SW-3:0];
         inc_d  = 1'b0;
      end
   end

   lden_reg #(.W(SW+3)) u_norm_reg (
      .clk (clk), .rst (rst), .en (state == NORM),
      .d   ({frac_d, g_d, s_d, inc_d, zero_d}),
      .q   ({frac_q, g_q, s_q, inc_q, zero_q})
   );

   logic          r;
   logic [SW-1:0] sum;
   logic          carry;

   round_incr u_round_incr (
      .g (g_q), .s (s_q), .lsb (frac_q[0]), .sign (sign_q), .rmode (rmode_q),
      .r (r)
   );

   assign sum   = {1'b0, frac_q} + SW'(r);
   assign carry = sum[SW-1] & ~zero_q;

   logic [SW-2:0] res_frac;
   logic          res_inex;
   logic [1:0]    res_inc, res_inc_d;

   lden_reg #(.W(SW)) u_res_reg (
      .clk (clk), .rst (rst), .en (state == ROUND),
      .d   (zero_q ? '0 : {sum[SW-2:0], g_q | s_q}),
      .q   ({res_frac, res_inex})
   );

   // On carry the fraction is already all zeros; RENORM only bumps the exponent.
   assign res_inc_d = (state == RENORM) ? ({1'b0, inc_q} + 2'd1)
                    : (zero_q ? 2'd0 : {1'b0, inc_q});

   lden_reg #(.W(2)) u_inc_reg (
      .clk (clk), .rst (rst), .en ((state == ROUND) || (state == RENORM)),
      .d   (res_inc_d),
      .q   (res_inc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ready_o    <= 1'b1;
         valid_o    <= 1'b0;
         sgf_frac_o <= '0;
         exp_inc_o  <= '0;
         inexact_o  <= 1'b0;
         zero_o     <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            IDLE: if (start_i) begin
               state   <= NORM;
               ready_o <= 1'b0;
            end
            NORM:   state <= ROUND;
            ROUND:  state <= carry ? RENORM : DONE;
            RENORM: state <= DONE;
            DONE: begin
               state      <= IDLE;
               ready_o    <= 1'b1;
               valid_o    <= 1'b1;
               sgf_frac_o <= res_frac;
               exp_inc_o  <= res_inc;
               inexact_o  <= res_inex;
               zero_o     <= zero_q;
            end
            default: begin
               state   <= IDLE;
               ready_o <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sgf_norm_round.sv
// Self-checking bench for sgf_norm_round (SW=24): vector table feeding a
// scoreboard, plus busy-start and mid-operation reset sequences.
module tb_sgf_norm_round;
   import fpu_pkg::*;

   localparam int SW = 24;

   logic            clk = 1'b0;
   logic            rst;
   logic            start_i;
   logic [2*SW-1:0] sgf_prod_i;
   logic            sign_i;
   logic [1:0]      rmode_i;
   logic            ready_o, valid_o;
   logic [SW-2:0]   sgf_frac_o;
   logic [1:0]      exp_inc_o;
   logic            inexact_o, zero_o;

   sgf_norm_round #(.SW(SW)) dut (
      .clk (clk), .rst (rst), .start_i (start_i), .sgf_prod_i (sgf_prod_i),
      .sign_i (sign_i), .rmode_i (rmode_i), .ready_o (ready_o), .valid_o (valid_o),
      .sgf_frac_o (sgf_frac_o), .exp_inc_o (exp_inc_o), .inexact_o (inexact_o),
      .zero_o (zero_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*SW-1:0] p;
      logic            sign;
      logic [1:0]      rm;
      logic [SW-2:0]   frac;
      logic [1:0]      inc;
      logic            inex;
      logic            zero;
      int              lat;
   } vec_t;

   typedef struct {
      logic [SW-2:0] frac;
      logic [1:0]    inc;
      logic          inex;
      logic          zero;
      int            lat;
      int            start_cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   nvalid = 0;
   vec_t vecs[15];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [2*SW-1:0] p, input logic sign, input logic [1:0] rm,
                               input logic [SW-2:0] frac, input logic [1:0] inc,
                               input logic inex, input logic zero, input int lat);
      vec_t v;
      v.p = p; v.sign = sign; v.rm = rm; v.frac = frac; v.inc = inc;
      v.inex = inex; v.zero = zero; v.lat = lat;
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_o) begin
         nvalid++;
         if (sb.size() == 0) begin
            check("spurious_valid", 64'(valid_o), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("frac",    64'(sgf_frac_o), 64'(e.frac));
            check("exp_inc", 64'(exp_inc_o),  64'(e.inc));
            check("inexact", 64'(inexact_o),  64'(e.inex));
            check("zero",    64'(zero_o),     64'(e.zero));
            check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
         end
      end
   end

   task automatic drive(input vec_t v);
      exp_t e;
      int   n = 0;
      while (!ready_o && n < 20) begin @(negedge clk); n++; end
      check("ready_before_start", 64'(ready_o), 64'd1);
      sgf_prod_i = v.p; sign_i = v.sign; rmode_i = v.rm; start_i = 1'b1;
      e.frac = v.frac; e.inc = v.inc; e.inex = v.inex; e.zero = v.zero;
      e.lat = v.lat; e.start_cyc = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
      if (sb.size() != 0) begin
         check("result_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   initial begin
      int nv0;
      vecs[0]  = mk(48'h4000_0000_0000, 1'b0, RM_RNE,  23'h000000, 2'd0, 1'b0, 1'b0, 3);
      vecs[1]  = mk(48'h8000_0000_0000, 1'b0, RM_RNE,  23'h000000, 2'd1, 1'b0, 1'b0, 3);
      vecs[2]  = mk(48'h4000_0040_0000, 1'b0, RM_RNE,  23'h000000, 2'd0, 1'b1, 1'b0, 3);
      vecs[3]  = mk(48'h4000_00C0_0000, 1'b0, RM_RNE,  23'h000002, 2'd0, 1'b1, 1'b0, 3);
      vecs[4]  = mk(48'h7FFF_FFC0_0000, 1'b0, RM_RNE,  23'h000000, 2'd1, 1'b1, 1'b0, 4);
      vecs[5]  = mk(48'h7FFF_FFC0_0000, 1'b0, RM_RTZ,  23'h7FFFFF, 2'd0, 1'b1, 1'b0, 3);
      vecs[6]  = mk(48'h4000_0000_0001, 1'b0, RM_PINF, 23'h000001, 2'd0, 1'b1, 1'b0, 3);
      vecs[7]  = mk(48'h4000_0000_0001, 1'b1, RM_PINF, 23'h000000, 2'd0, 1'b1, 1'b0, 3);
      vecs[8]  = mk(48'h4000_0000_0001, 1'b1, RM_NINF, 23'h000001, 2'd0, 1'b1, 1'b0, 3);
      vecs[9]  = mk(48'h0000_0000_0000, 1'b0, RM_RNE,  23'h000000, 2'd0, 1'b0, 1'b1, 3);
      vecs[10] = mk(48'hFFFF_FF80_0000, 1'b0, RM_RNE,  23'h000000, 2'd2, 1'b1, 1'b0, 4);
      vecs[11] = mk(48'h8000_0180_0000, 1'b0, RM_RNE,  23'h000002, 2'd1, 1'b1, 1'b0, 3);
      vecs[12] = mk(48'h3FFF_FFFF_FFFF, 1'b1, RM_NINF, 23'h000000, 2'd0, 1'b0, 1'b1, 3);
      vecs[13] = mk(48'h4000_0060_0000, 1'b0, RM_RNE,  23'h000001, 2'd0, 1'b1, 1'b0, 3);
      vecs[14] = mk(48'h8000_00FF_FFFF, 1'b1, RM_RTZ,  23'h000000, 2'd1, 1'b1, 1'b0, 3);

      rst = 1'b1; start_i = 1'b0; sgf_prod_i = '0; sign_i = 1'b0; rmode_i = RM_RNE;
      repeat (3) @(negedge clk);
      check("rst_ready",   64'(ready_o),    64'd1);
      check("rst_valid",   64'(valid_o),    64'd0);
      check("rst_frac",    64'(sgf_frac_o), 64'd0);
      check("rst_exp_inc", 64'(exp_inc_o),  64'd0);
      check("rst_inexact", 64'(inexact_o),  64'd0);
      check("rst_zero",    64'(zero_o),     64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i]);
         @(negedge clk);
         start_i = 1'b0;
         check("busy_not_ready", 64'(ready_o), 64'd0);
         drain();
      end

      // start held through NORM/ROUND with changing data: one result only
      nv0 = nvalid;
      drive(vecs[3]);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         sgf_prod_i = 48'hFFFF_FFFF_FFFF; sign_i = 1'b1; rmode_i = RM_NINF;
      end
      @(negedge clk);
      start_i = 1'b0;
      drain();
      repeat (8) @(negedge clk);
      check("held_start_one_valid", 64'(nvalid - nv0), 64'd1);

      // reset while in ROUND aborts with no result
      drive(vecs[14]);
      sb.delete();
      nv0 = nvalid;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_ready", 64'(ready_o), 64'd1);
      check("abort_valid", 64'(valid_o), 64'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("abort_no_valid", 64'(nvalid - nv0), 64'd0);
      check("abort_ready_idle", 64'(ready_o), 64'd1);

      // still functional after abort
      drive(vecs[4]);
      @(negedge clk);
      start_i = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
